// File: rtl/md5_pkg.sv
// MD5 constants, state encoding and per-step helper functions
// shared by the stream core and its combinational step.
package md5_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [3:0] gidx(input logic [5:0] i);
    logic [3:0] t;
    t = i[3:0];
    case (i[5:4])
      2'd0:    return t;
      2'd1:    return t * 4'd5 + 4'd1;
      2'd2:    return t * 4'd3 + 4'd5;
      default: return t * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] fsel(
    input logic [1:0]  r,
    input logic [31:0] b,
    input logic [31:0] c,
    input logic [31:0] d
  );
    case (r)
      2'd0:    return (b & c) | (~b & d);
      2'd1:    return (d & b) | (~d & c);
      2'd2:    return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input logic [4:0]  s
  );
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_stream_core_if.sv
// Block-in / digest-out handshake bundle for md5_stream_core.
interface md5_stream_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic [0:511] in_data;
  logic         hash_valid;
  logic         hash_ready;
  logic [0:127] hash;
  logic         busy;

  modport slave (
    input  in_valid, in_first, in_last, in_data, hash_ready,
    output in_ready, hash_valid, hash, busy
  );

  modport master (
    output in_valid, in_first, in_last, in_data, hash_ready,
    input  in_ready, hash_valid, hash, busy
  );
endinterface

// File: rtl/md5_step.sv
// One combinational MD5 step: (a,b,c,d) -> rotated next state.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [5:0]  step,
  output logic [31:0] a_nx,
  output logic [31:0] b_nx,
  output logic [31:0] c_nx,
  output logic [31:0] d_nx
);
  logic [31:0] tmp;

  assign tmp  = a + fsel(step[5:4], b, c, d) + K[step] + m;
  assign a_nx = d;
  assign b_nx = b + rotl(tmp, S[step]);
  assign c_nx = b;
  assign d_nx = c;
endmodule

// File: rtl/md5_stream_core.sv
// Multi-block MD5 compressor with first/last chaining and
// STEPS_PER_CYCLE unrolled steps per clock.
module md5_stream_core
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              h_rst,
  md5_stream_core_if.slave bus
);
  localparam int SPC = STEPS_PER_CYCLE;

  if (SPC != 1 && SPC != 2 && SPC != 4) begin : g_bad
    $error("STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t      state, state_nx;
  logic [5:0]  step;
  logic        first_flag, last_flag;
  logic [31:0] a, b, c, d;
  logic [31:0] ca, cb, cc, cd;
  logic [31:0] ba, bb, bc, bd;
  logic [31:0] sa, sb, sc, sd;
  logic [31:0] msg [16];
  logic [31:0] wa [SPC+1];
  logic [31:0] wb [SPC+1];
  logic [31:0] wc [SPC+1];
  logic [31:0] wd [SPC+1];
  logic        round_end;

  assign wa[0] = a;
  assign wb[0] = b;
  assign wc[0] = c;
  assign wd[0] = d;

  for (genvar k = 0; k < SPC; k++) begin : g_step
    logic [5:0] st;
    assign st = step + 6'(k);
    md5_step u_step (
      .a(wa[k]), .b(wb[k]), .c(wc[k]), .d(wd[k]),
      .m(msg[gidx(st)]),
      .step(st),
      .a_nx(wa[k+1]), .b_nx(wb[k+1]),
      .c_nx(wc[k+1]), .d_nx(wd[k+1])
    );
  end

  assign round_end = (step == 6'(64 - SPC));

  assign ba = first_flag ? IV_A : ca;
  assign bb = first_flag ? IV_B : cb;
  assign bc = first_flag ? IV_C : cc;
  assign bd = first_flag ? IV_D : cd;
  assign sa = ba + a;
  assign sb = bb + b;
  assign sc = bc + c;
  assign sd = bd + d;

  assign bus.in_ready   = (state == IDLE);
  assign bus.hash_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nx = ROUND;
      ROUND: if (round_end) state_nx = FINAL;
      FINAL: state_nx = last_flag ? DONE : IDLE;
      DONE:  if (bus.hash_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The message buffer only changes on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      for (int j = 0; j < 16; j++)
        msg[j] <= bswap32(bus.in_data[32*j +: 32]);
    end
  end

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      step       <= '0;
      first_flag <= 1'b1;
      last_flag  <= 1'b0;
      a  <= IV_A; b  <= IV_B; c  <= IV_C; d  <= IV_D;
      ca <= IV_A; cb <= IV_B; cc <= IV_C; cd <= IV_D;
      bus.hash <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          first_flag <= bus.in_first;
          last_flag  <= bus.in_last;
          step       <= '0;
          a <= bus.in_first ? IV_A : ca;
          b <= bus.in_first ? IV_B : cb;
          c <= bus.in_first ? IV_C : cc;
          d <= bus.in_first ? IV_D : cd;
        end
        ROUND: begin
          a    <= wa[SPC];
          b    <= wb[SPC];
          c    <= wc[SPC];
          d    <= wd[SPC];
          step <= step + 6'(SPC);
        end
        FINAL: begin
          ca <= sa; cb <= sb; cc <= sc; cd <= sd;
          if (last_flag)
            bus.hash <= {bswap32(sa), bswap32(sb),
                         bswap32(sc), bswap32(sd)};
        end
        default: ;
      endcase
    end
  end
endmodule
